// File: rtl/cdc_clear_sequencer.sv
// Local-domain master of the CDC clear sequence: IDLE -> ISOLATE -> CLEAR -> POST_CLEAR -> IDLE,
// each phase published over a valid/ready handshake. Optional statistics: CDC_CLEAR_SEQ_STATS_EN.
module cdc_clear_sequencer #(
    parameter int unsigned NumChannels     = 1,
    parameter int unsigned ClearCycles     = 4,
    parameter int unsigned PostClearCycles = 2,
    parameter int unsigned TimeoutCycles   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    output logic [NumChannels-1:0] isolate_o,
    input  logic [NumChannels-1:0] isolate_ack_i,
    output logic                   clear_o,
    output logic [1:0]             phase_o,
    output logic                   phase_valid_o,
    input  logic                   phase_ready_i,
    output logic                   busy_o,
    output logic                   timeout_o
`ifdef CDC_CLEAR_SEQ_STATS_EN
    ,
    output logic [15:0]            seq_count_o,
    output logic [7:0]             timeout_count_o
`endif
);

    localparam int unsigned MaxAB     = (ClearCycles > PostClearCycles) ? ClearCycles : PostClearCycles;
    localparam int unsigned MaxCycles = (MaxAB > TimeoutCycles) ? MaxAB : TimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] ClrLast = CntW'(ClearCycles - 1);
    localparam logic [CntW-1:0] ClrSat  = CntW'(ClearCycles);
    localparam logic [CntW-1:0] PostMin = CntW'(PostClearCycles);
    localparam logic [CntW-1:0] ToLast  = CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    typedef enum logic [1:0] {
        PH_IDLE       = 2'd0,
        PH_ISOLATE    = 2'd1,
        PH_CLEAR      = 2'd2,
        PH_POST_CLEAR = 2'd3
    } phase_e;

    phase_e          state;
    logic            hs_done;
    logic            pending;
    logic [CntW-1:0] cnt;

    logic hs_fire;
    logic hs_ok;
    logic all_ack;
    logic timed_out;

    // The transfer cycle itself already counts as handshake complete, so an exit
    // can share the edge on which phase_valid_o drops.
    always_comb begin
        hs_fire   = phase_valid_o & phase_ready_i;
        hs_ok     = hs_done | hs_fire;
        all_ack   = &isolate_ack_i;
        timed_out = (TimeoutCycles != 0) && (cnt == ToLast) && !all_ack;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= PH_IDLE;
            phase_o       <= PH_IDLE;
            phase_valid_o <= 1'b0;
            hs_done       <= 1'b0;
            pending       <= 1'b0;
            cnt           <= '0;
            isolate_o     <= '0;
            clear_o       <= 1'b0;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            if (hs_fire) begin
                phase_valid_o <= 1'b0;
                hs_done       <= 1'b1;
            end
            if (clear_i && busy_o) begin
                pending <= 1'b1;
            end

            unique case (state)
                PH_IDLE: begin
                    if (hs_fire) begin
                        busy_o <= 1'b0;
                    end
                    // busy_o low in IDLE means the IDLE phase has been accepted remotely.
                    if (!busy_o && (clear_i || pending)) begin
                        state         <= PH_ISOLATE;
                        phase_o       <= PH_ISOLATE;
                        phase_valid_o <= 1'b1;
                        hs_done       <= 1'b0;
                        cnt           <= '0;
                        pending       <= 1'b0;
                        timeout_o     <= 1'b0;
                        busy_o        <= 1'b1;
                        isolate_o     <= '1;
                    end
                end

                PH_ISOLATE: begin
                    if (cnt != ToLast) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (timed_out) begin
                        timeout_o <= 1'b1;
                    end
                    if (hs_ok && (all_ack || timed_out)) begin
                        state         <= PH_CLEAR;
                        phase_o       <= PH_CLEAR;
                        phase_valid_o <= 1'b1;
                        hs_done       <= 1'b0;
                        cnt           <= '0;
                        clear_o       <= 1'b1;
                    end
                end

                PH_CLEAR: begin
                    if (cnt < ClrSat) begin
                        cnt <= cnt + 1'b1;
                    end
                    // cnt counts completed cycles, so the exit edge ends the ClearCycles-th cycle.
                    if (hs_ok && (cnt >= ClrLast)) begin
                        state         <= PH_POST_CLEAR;
                        phase_o       <= PH_POST_CLEAR;
                        phase_valid_o <= 1'b1;
                        hs_done       <= 1'b0;
                        cnt           <= '0;
                        clear_o       <= 1'b0;
                    end
                end

                PH_POST_CLEAR: begin
                    if (cnt != PostMin) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (hs_ok && (cnt == PostMin)) begin
                        state         <= PH_IDLE;
                        phase_o       <= PH_IDLE;
                        phase_valid_o <= 1'b1;
                        hs_done       <= 1'b0;
                        cnt           <= '0;
                        isolate_o     <= '0;
                    end
                end

                default: begin
                    state <= PH_IDLE;
                end
            endcase
        end
    end

`ifdef CDC_CLEAR_SEQ_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_count_o     <= '0;
            timeout_count_o <= '0;
        end else begin
            if (state == PH_IDLE && hs_fire) begin
                seq_count_o <= seq_count_o + 16'd1;
            end
            // Counted once per sequence: timeout_o is cleared on every sequence start.
            if (state == PH_ISOLATE && timed_out && !timeout_o && timeout_count_o != '1) begin
                timeout_count_o <= timeout_count_o + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdc_clear_sequencer.sv
// Scoreboard bench for cdc_clear_sequencer: random ack delays, ready stalls and queued requests
// checked against phase durations computed from the sequencing rules.
module tb_cdc_clear_sequencer;

    localparam int NSEQ = 24;
    localparam int CLR  = 4;
    localparam int POST = 2;
    localparam int TMO  = 8;

    typedef struct {
        int unsigned d;
        bit          never;
        int unsigned s[4];
        int unsigned extra;
        bit          tmo;
    } cfg_t;

    typedef struct {
        logic [1:0] ph;
        int         dur;
        int         tmo;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clear_i;
    logic [1:0] isolate_o;
    logic [1:0] isolate_ack_i;
    logic       clear_o;
    logic [1:0] phase_o;
    logic       phase_valid_o;
    logic       phase_ready_i;
    logic       busy_o;
    logic       timeout_o;
`ifdef CDC_CLEAR_SEQ_STATS_EN
    logic [15:0] seq_count_o;
    logic [7:0]  timeout_count_o;
`endif

    cdc_clear_sequencer #(
        .NumChannels    (2),
        .ClearCycles    (CLR),
        .PostClearCycles(POST),
        .TimeoutCycles  (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .isolate_o    (isolate_o),
        .isolate_ack_i(isolate_ack_i),
        .clear_o      (clear_o),
        .phase_o      (phase_o),
        .phase_valid_o(phase_valid_o),
        .phase_ready_i(phase_ready_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
`ifdef CDC_CLEAR_SEQ_STATS_EN
        ,
        .seq_count_o    (seq_count_o),
        .timeout_count_o(timeout_count_o)
`endif
    );

    initial forever #5 clk_i = ~clk_i;

    int   checks = 0;
    int   errors = 0;
    int   seqs_done = 0;
    bit   mon_en = 1'b0;
    cfg_t cfg_q[$];
    exp_t exp_q[$];
    cfg_t seqs[NSEQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(negedge clk_i);
        #2;
    endtask

    // Driver: per-phase ready stalls and per-sequence ack timing.
    bit          drv_pres = 1'b0;
    bit          drv_lv = 1'b0;
    bit          drv_lr = 1'b0;
    bit          drv_fired;
    int unsigned drv_stall = 0;
    int unsigned drv_iso = 0;
    cfg_t        drv_cur;

    initial begin
        phase_ready_i = 1'b1;
        isolate_ack_i = '0;
        drv_cur.d = 1;
        drv_cur.never = 1'b0;
        drv_cur.extra = 0;
        drv_cur.tmo = 1'b0;
        for (int p = 0; p < 4; p++) drv_cur.s[p] = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                drv_pres = 1'b0;
                drv_lv = 1'b0;
                drv_lr = 1'b0;
                drv_stall = 0;
                phase_ready_i = 1'b1;
                isolate_ack_i = '0;
                continue;
            end
            drv_fired = drv_lv && drv_lr;
            if (phase_valid_o && (!drv_pres || drv_fired)) begin
                drv_pres = 1'b1;
                if (phase_o == 2'd1) begin
                    if (cfg_q.size() > 0) drv_cur = cfg_q.pop_front();
                    drv_iso = 0;
                end
                drv_stall = drv_cur.s[phase_o];
            end else if (drv_fired) begin
                drv_pres = 1'b0;
            end
            if (drv_pres && drv_stall > 0) begin
                phase_ready_i = 1'b0;
                drv_stall--;
            end else begin
                phase_ready_i = 1'b1;
            end
            if (isolate_o == 2'b00) begin
                isolate_ack_i = '0;
            end else begin
                isolate_ack_i = (!drv_cur.never && drv_iso >= drv_cur.d) ? 2'b11 : 2'b01;
                drv_iso++;
            end
            drv_lv = phase_valid_o;
            drv_lr = phase_ready_i;
        end
    end

    // Monitor: pops one expectation per phase transfer and checks phase durations.
    logic [1:0] mon_prev_ph = 2'd0;
    logic [1:0] mon_prev_pv = 2'd0;
    int         mon_cyc = 0;
    int         mon_dur = -1;
    bit         mon_chk_busy = 1'b0;
    bit         mon_pv = 1'b0;
    bit         mon_pr = 1'b0;
    exp_t       mon_e;

    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni || !mon_en) begin
                mon_prev_ph = phase_o;
                mon_cyc = 0;
                mon_dur = -1;
                mon_chk_busy = 1'b0;
                mon_pv = 1'b0;
                continue;
            end
            check("clear_vs_phase", clear_o, phase_o == 2'd2);
            check("isolate_vs_phase", isolate_o, (phase_o != 2'd0) ? 2'b11 : 2'b00);
            if (mon_chk_busy) begin
                check("busy_after_idle_hs", busy_o, 0);
                mon_chk_busy = 1'b0;
            end
            if (mon_pv && !mon_pr) begin
                check("valid_held", phase_valid_o, 1);
                check("phase_held", phase_o, mon_prev_pv);
            end
            if (phase_o != mon_prev_ph) begin
                if (mon_dur >= 0) check($sformatf("dur_phase%0d", mon_prev_ph), mon_cyc, mon_dur);
                mon_dur = -1;
                mon_cyc = 1;
                mon_prev_ph = phase_o;
            end else begin
                mon_cyc++;
            end
            if (phase_valid_o && phase_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handshake actual=phase%0d expected=none at %0t", phase_o, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("hs_phase", phase_o, mon_e.ph);
                    if (mon_e.tmo >= 0) check("hs_timeout", timeout_o, mon_e.tmo);
                    mon_dur = mon_e.dur;
                    if (mon_e.ph == 2'd0) begin
                        check("busy_at_idle_hs", busy_o, 1);
                        mon_chk_busy = 1'b1;
                        seqs_done++;
                    end
                end
            end
            mon_pv = phase_valid_o;
            mon_pr = phase_ready_i;
            mon_prev_pv = phase_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    int   n;
    int   a;
    int   ntmo = 0;
    bit   active;
    cfg_t c;
    exp_t e;

    initial begin
        rst_ni = 1'b0;
        clear_i = 1'b0;
        #12;
        check("rst_phase", phase_o, 0);
        check("rst_valid", phase_valid_o, 0);
        check("rst_isolate", isolate_o, 0);
        check("rst_clear", clear_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_timeout", timeout_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int k = 0; k < NSEQ; k++) begin
            c.d = $urandom_range(1, 9);
            c.never = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < 4; p++) c.s[p] = ($urandom_range(0, 6) == 0) ? 10 : $urandom_range(0, 3);
            c.extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            if (k == 1) c.s[2] = 10;
            if (k == 2) c.never = 1'b1;
            if (k == 3) c.extra = 3;
            if (k == NSEQ - 1) c.extra = 0;
            c.tmo = c.never || (c.d >= 8);
            if (c.tmo) ntmo++;
            a = c.tmo ? TMO - 1 : int'(c.d);
            seqs[k] = c;
            cfg_q.push_back(c);
            e.ph = 2'd1; e.dur = mx(c.s[1], a) + 1;        e.tmo = -1;    exp_q.push_back(e);
            e.ph = 2'd2; e.dur = mx(c.s[2], CLR - 1) + 1;  e.tmo = c.tmo; exp_q.push_back(e);
            e.ph = 2'd3; e.dur = mx(c.s[3], POST) + 1;     e.tmo = c.tmo; exp_q.push_back(e);
            e.ph = 2'd0; e.dur = (c.extra != 0) ? int'(c.s[0]) + 2 : -1; e.tmo = c.tmo; exp_q.push_back(e);
        end
        mon_en = 1'b1;

        for (int k = 0; k < NSEQ; k++) begin
            if (k == 0 || seqs[k-1].extra == 0) begin
                repeat ($urandom_range(1, 4)) tick();
                check("idle_phase", phase_o, 0);
                check("idle_busy", busy_o, 0);
                check("idle_timeout_sticky", timeout_o, (k == 0) ? 1'b0 : seqs[k-1].tmo);
                clear_i = 1'b1;
                tick();
                clear_i = 1'b0;
                check("start_phase", phase_o, 1);
                check("start_busy", busy_o, 1);
            end
            n = 0;
            while (phase_o != 2'd2 && n < 200) begin tick(); n++; end
            check("reach_clear", phase_o, 2);
            for (int j = 0; j < int'(seqs[k].extra); j++) begin
                clear_i = 1'b1;
                tick();
                clear_i = 1'b0;
                tick();
            end
            n = 0;
            while (seqs_done < k + 1 && n < 300) begin tick(); n++; end
            check("seq_done", seqs_done, k + 1);
        end
        repeat (3) tick();
        check("final_idle_busy", busy_o, 0);
        check("final_idle_phase", phase_o, 0);
`ifdef CDC_CLEAR_SEQ_STATS_EN
        check("seq_count", seq_count_o, NSEQ);
        check("timeout_count", timeout_count_o, ntmo);
`endif

        mon_en = 1'b0;
        c.d = 1; c.never = 1'b0; c.extra = 0; c.tmo = 1'b0;
        for (int p = 0; p < 4; p++) c.s[p] = 0;
        cfg_q.push_back(c);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n = 0;
        while (phase_o != 2'd2 && n < 100) begin tick(); n++; end
        check("rst_test_reach_clear", phase_o, 2);
        @(posedge clk_i);
        #2;
        check("rst_test_clear_before", clear_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_clear", clear_o, 0);
        check("midrst_isolate", isolate_o, 0);
        check("midrst_valid", phase_valid_o, 0);
        check("midrst_phase", phase_o, 0);
        check("midrst_busy", busy_o, 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        cfg_q.delete();
        exp_q.delete();
        active = 1'b0;
        repeat (20) begin
            tick();
            if (phase_valid_o || busy_o || clear_o || (isolate_o != 2'b00)) active = 1'b1;
        end
        check("quiet_after_reset", active, 0);
`ifdef CDC_CLEAR_SEQ_STATS_EN
        check("stats_reset_seq", seq_count_o, 0);
        check("stats_reset_tmo", timeout_count_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
